// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: x - y - br -> difference bit d and borrow out br_next.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor {bo, diff} = a - b - bi, LSB first,
// with valid/ready handshakes on operands and result.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               borrow_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bo_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               d_s;
    logic               br_s;

    full_subtractor_bit u_bit (
        .x       (a_sh_r[0]),
        .y       (b_sh_r[0]),
        .br      (borrow_r),
        .d       (d_s),
        .br_next (br_s)
    );

    // Next-state logic; the unused encoding falls back to idle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) state_s = S_SHIFT;
                else          state_s = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_r == CNT_LAST) state_s = S_DONE;
                else                   state_s = S_SHIFT;
            end
            S_DONE: begin
                if (out_ready) state_s = S_IDLE;
                else           state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, handshake flags and serial datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            borrow_r    <= 1'b0;
            diff_r      <= '0;
            bo_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == S_IDLE);
            out_valid_r <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= bi;
                        cnt_r    <= '0;
                    end
                end
                S_SHIFT: begin
                    // Result bits fill the vacated MSBs of a_sh, so diff is only
                    // loaded once, with the complete word, on the last bit.
                    a_sh_r   <= {d_s, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    borrow_r <= br_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        diff_r <= {d_s, a_sh_r[WIDTH-1:1]};
                        bo_r   <= br_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bo        = bo_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic a-b-bi model.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             bi        = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bo;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bo        (bo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, shift (optionally with junk on the inputs),
    // hold under back-pressure for `stall` cycles, then hand the result over.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic obi,
                          input int stall, input bit junk);
        int         r;
        int         lat;
        int         guard;
        logic [7:0] ed;
        logic       eb;
        r  = int'(oa) - int'(ob) - int'(obi);
        ed = r[7:0];
        eb = (r < 0);
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick;
            guard++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        a = oa; b = ob; bi = obi; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 4 * WIDTH) begin
            chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
            if (junk) begin
                in_valid = 1'($urandom);
                a        = 8'($urandom);
                b        = 8'($urandom);
                bi       = 1'($urandom);
            end
            tick;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, WIDTH);
        chk("diff", {24'd0, diff}, {24'd0, ed});
        chk("bo", {31'd0, bo}, {31'd0, eb});
        for (int i = 0; i < stall; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_diff", {24'd0, diff}, {24'd0, ed});
            chk("hold_bo", {31'd0, bo}, {31'd0, eb});
            chk("done_in_ready", {31'd0, in_ready}, 32'd0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        chk("kept_diff", {24'd0, diff}, {24'd0, ed});
        chk("kept_bo", {31'd0, bo}, {31'd0, eb});
    endtask

    initial begin
        tick;
        tick;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_bo", {31'd0, bo}, 32'd0);
        reset_n = 1'b1;
        tick;

        run_op(8'd10, 8'd3, 1'b0, 0, 1'b0);
        run_op(8'd0, 8'd0, 1'b1, 0, 1'b0);
        run_op(8'd255, 8'd255, 1'b0, 2, 1'b1);
        run_op(8'd0, 8'd255, 1'b1, 20, 1'b0);
        run_op(8'd2, 8'd15, 1'b0, 0, 1'b0);

        // Abort in the middle of the shift: nothing partial may surface.
        a = 8'd200; b = 8'd100; bi = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_bo", {31'd0, bo}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        tick;
        reset_n = 1'b1;
        tick;
        chk("after_abort_ready", {31'd0, in_ready}, 32'd1);
        run_op(8'd100, 8'd1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
